// File: rtl/marx_pkg.sv
// Purpose: shared widths and the result-entry type for the Marx upstream path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package marx_pkg;

  localparam int WRESULT  = 32;  // APU result width
  localparam int NUSFLAGS = 9;   // upstream flags (9 for FPU, 3 for LNU)
  localparam int WCPUTAG  = 5;   // core-local tag width
  localparam int NCPUS    = 8;   // cores sharing the APU
  localparam int WCPUID   = $clog2(NCPUS);
  localparam int WAPUTAG  = WCPUTAG + WCPUID;  // {cpu_id, cpu_tag}

  typedef struct packed {
    logic [WRESULT-1:0]  result;
    logic [NUSFLAGS-1:0] flags;
    logic [WAPUTAG-1:0]  tag;
  } us_entry_t;

endpackage

// File: rtl/marx_us_fifo_mem.sv
// Purpose: DEPTH x WIDTH register array, one synchronous write port, one async read port.
// Latency: write visible on rdata the cycle after we; read is combinational.
// Backpressure: none; the caller owns pointers and full/empty.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module marx_us_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Storage is deliberately not reset; the owner masks outputs while empty.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/marx_us_result_buffer.sv
// Purpose: in-order result buffer from the shared APU to the Marx interconnect; splits tag into core id/tag.
// Latency: an entry pushed in cycle N is offered on us_req_o in cycle N+1; no bypass.
// Backpressure: apu_ack_o drops only when full (registered state only); one push and one pop per cycle.
// Ports: clk_i/rst_i/flush_i; APU side apu_req_i/apu_ack_o + result/flags/tag;
//        interconnect side us_req_o/us_ack_i + result/flags/tag/cpu_id/cpu_tag; count_o occupancy.
module marx_us_result_buffer
  import marx_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WRESULT  = marx_pkg::WRESULT,
  parameter int NUSFLAGS = marx_pkg::NUSFLAGS,
  parameter int WCPUTAG  = marx_pkg::WCPUTAG,
  parameter int NCPUS    = marx_pkg::NCPUS
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 apu_req_i,
  output logic                                 apu_ack_o,
  input  logic [WRESULT-1:0]                   apu_result_i,
  input  logic [NUSFLAGS-1:0]                  apu_flags_i,
  input  logic [WCPUTAG+$clog2(NCPUS)-1:0]     apu_tag_i,
  output logic                                 us_req_o,
  input  logic                                 us_ack_i,
  output logic [WRESULT-1:0]                   us_result_o,
  output logic [NUSFLAGS-1:0]                  us_flags_o,
  output logic [WCPUTAG+$clog2(NCPUS)-1:0]     us_tag_o,
  output logic [$clog2(NCPUS)-1:0]             us_cpu_id_o,
  output logic [WCPUTAG-1:0]                   us_cpu_tag_o,
  output logic [$clog2(DEPTH):0]               count_o
);

  localparam int WID    = $clog2(NCPUS);
  localparam int WTAG   = WCPUTAG + WID;
  localparam int WENTRY = WRESULT + NUSFLAGS + WTAG;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;
  logic [WENTRY-1:0] head;
  logic [WENTRY-1:0] wdata;

  // Handshakes depend on registered occupancy only, so there is no
  // combinational path from us_ack_i to apu_ack_o. A full buffer refuses a
  // push even if the head is popped in the same cycle.
  assign apu_ack_o = (count_q != CW'(DEPTH));
  assign us_req_o  = (count_q != '0);
  assign push      = apu_req_i & apu_ack_o;
  assign pop       = us_req_o & us_ack_i;
  assign count_o   = count_q;

  assign wdata = {apu_result_i, apu_flags_i, apu_tag_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      // Flush wins over any push or pop presented in the same cycle.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  marx_us_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WENTRY)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Data outputs read zero while empty, which also gives the zero reset
  // value without resetting the storage array.
  assign us_result_o  = us_req_o ? head[WENTRY-1 -: WRESULT]        : '0;
  assign us_flags_o   = us_req_o ? head[WTAG +: NUSFLAGS]           : '0;
  assign us_tag_o     = us_req_o ? head[WTAG-1:0]                   : '0;
  assign us_cpu_id_o  = us_tag_o[WTAG-1:WCPUTAG];
  assign us_cpu_tag_o = us_tag_o[WCPUTAG-1:0];

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && (count_q == CW'(DEPTH))));

  a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (us_req_o && !us_ack_i && !flush_i) |=> $stable({us_result_o, us_flags_o, us_tag_o}));

  a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_marx_us_result_buffer.sv
// Purpose: scoreboard bench for marx_us_result_buffer with directed vectors.
// Latency: driver records expected entries on acceptance; monitor compares on each pop.
// Backpressure: us_ack_i is driven per vector to exercise full, empty and flush cases.
module tb_marx_us_result_buffer;
  import marx_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                apu_req;
  logic                apu_ack;
  logic [WRESULT-1:0]  apu_result;
  logic [NUSFLAGS-1:0] apu_flags;
  logic [WAPUTAG-1:0]  apu_tag;
  logic                us_req;
  logic                us_ack;
  logic [WRESULT-1:0]  us_result;
  logic [NUSFLAGS-1:0] us_flags;
  logic [WAPUTAG-1:0]  us_tag;
  logic [WCPUID-1:0]   us_cpu_id;
  logic [WCPUTAG-1:0]  us_cpu_tag;
  logic [CW-1:0]       count;

  int checks   = 0;
  int failures = 0;

  us_entry_t exp_q[$];
  us_entry_t mon_e;

  always #5 clk = ~clk;

  marx_us_result_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .apu_req_i    (apu_req),
    .apu_ack_o    (apu_ack),
    .apu_result_i (apu_result),
    .apu_flags_i  (apu_flags),
    .apu_tag_i    (apu_tag),
    .us_req_o     (us_req),
    .us_ack_i     (us_ack),
    .us_result_o  (us_result),
    .us_flags_o   (us_flags),
    .us_tag_o     (us_tag),
    .us_cpu_id_o  (us_cpu_id),
    .us_cpu_tag_o (us_cpu_tag),
    .count_o      (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic us_entry_t mk(input logic [WRESULT-1:0] r, input logic [NUSFLAGS-1:0] f,
                                   input logic [WCPUID-1:0] c, input logic [WCPUTAG-1:0] t);
    us_entry_t e;
    e.result = r;
    e.flags  = f;
    e.tag    = {c, t};
    return e;
  endfunction

  // One clock cycle of stimulus. Inputs change 1 unit after the rising edge;
  // acceptance is judged at the falling edge from the DUT's registered ack.
  task automatic cyc(input logic req, input us_entry_t ent, input logic uack, input logic fl);
    apu_req    = req;
    apu_result = ent.result;
    apu_flags  = ent.flags;
    apu_tag    = ent.tag;
    us_ack     = uack;
    flush      = fl;
    @(negedge clk);
    if (fl) exp_q.delete();
    else if (req && apu_ack) exp_q.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pop();
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: every completed pop is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && us_req && us_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=none", us_result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("us_result",  64'(us_result),  64'(mon_e.result));
        chk("us_flags",   64'(us_flags),   64'(mon_e.flags));
        chk("us_tag",     64'(us_tag),     64'(mon_e.tag));
        chk("us_cpu_id",  64'(us_cpu_id),  64'(mon_e.tag[WAPUTAG-1:WCPUTAG]));
        chk("us_cpu_tag", 64'(us_cpu_tag), 64'(mon_e.tag[WCPUTAG-1:0]));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    apu_req    = 1'b0;
    apu_result = '0;
    apu_flags  = '0;
    apu_tag    = '0;
    us_ack     = 1'b0;

    // Reset state
    #12;
    chk("rst_count",   64'(count),     64'd0);
    chk("rst_us_req",  64'(us_req),    64'd0);
    chk("rst_apu_ack", 64'(apu_ack),   64'd1);
    chk("rst_result",  64'(us_result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single push, visible next cycle with tag split
    cyc(1'b1, mk(32'h3F80_0000, 9'h001, 3'd3, 5'd5), 1'b0, 1'b0);
    chk("t1_us_req",  64'(us_req),     64'd1);
    chk("t1_cpu_id",  64'(us_cpu_id),  64'd3);
    chk("t1_cpu_tag", 64'(us_cpu_tag), 64'd5);
    chk("t1_count",   64'(count),      64'd1);
    idle_pop();
    chk("t1_drain_count", 64'(count), 64'd0);

    // Empty: ack ignored; push with ack gives count 1
    idle_pop();
    chk("empty_ack_count", 64'(count),  64'd0);
    chk("empty_ack_req",   64'(us_req), 64'd0);
    cyc(1'b1, mk(32'h0000_00AA, 9'h1FF, 3'd7, 5'd31), 1'b1, 1'b0);
    chk("empty_pushpop_count", 64'(count), 64'd1);
    idle_pop();

    // 2: fill to DEPTH with ack held low; 5th refused; pop reopens
    for (int i = 0; i < 4; i++)
      cyc(1'b1, mk(32'h100 + 32'(i), 9'(i), 3'(i), 5'(i + 8)), 1'b0, 1'b0);
    chk("t2_full_count", 64'(count),   64'd4);
    chk("t2_full_ack",   64'(apu_ack), 64'd0);
    cyc(1'b1, mk(32'hDEAD, 9'h0, 3'd0, 5'd0), 1'b0, 1'b0);
    chk("t2_refused_count", 64'(count), 64'd4);
    idle_pop();
    chk("t2_pop_count", 64'(count),   64'd3);
    chk("t2_pop_ack",   64'(apu_ack), 64'd1);

    // 4: full + push + pop same cycle -> pop only
    cyc(1'b1, mk(32'h104, 9'h4, 3'd4, 5'd12), 1'b0, 1'b0);
    chk("t4_refill_count", 64'(count), 64'd4);
    cyc(1'b1, mk(32'hBAD, 9'h0, 3'd0, 5'd0), 1'b1, 1'b0);
    chk("t4_count", 64'(count),   64'd3);
    chk("t4_ack",   64'(apu_ack), 64'd1);
    for (int i = 0; i < 3; i++) idle_pop();
    chk("t4_drain_count", 64'(count), 64'd0);

    // 3: steady state at count 2, push + pop every cycle
    cyc(1'b1, mk(32'h200, 9'h10, 3'd1, 5'd1), 1'b0, 1'b0);
    cyc(1'b1, mk(32'h201, 9'h11, 3'd2, 5'd2), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, mk(32'h202 + 32'(i), 9'(i + 18), 3'(i), 5'(i)), 1'b1, 1'b0);
      chk("t3_count",  64'(count),  64'd2);
      chk("t3_us_req", 64'(us_req), 64'd1);
    end
    idle_pop();
    idle_pop();
    chk("t3_drain_count", 64'(count), 64'd0);

    // 5: pointer wrap, 10 push/pop pairs of values 0..9
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, mk(32'(i), 9'(i), 3'(i), 5'(i)), 1'b0, 1'b0);
      idle_pop();
    end
    chk("t5_count", 64'(count), 64'd0);

    // 6a: flush with count 3, overriding a simultaneous push and pop
    for (int i = 0; i < 3; i++)
      cyc(1'b1, mk(32'h300 + 32'(i), 9'h3, 3'd6, 5'(i)), 1'b0, 1'b0);
    chk("t6_pre_count", 64'(count), 64'd3);
    cyc(1'b1, mk(32'hF00, 9'h0, 3'd0, 5'd0), 1'b1, 1'b1);
    chk("t6_flush_count", 64'(count),   64'd0);
    chk("t6_flush_req",   64'(us_req),  64'd0);
    chk("t6_flush_ack",   64'(apu_ack), 64'd1);

    // 6b: async reset pulse mid-traffic
    cyc(1'b1, mk(32'h310, 9'h5, 3'd2, 5'd3), 1'b0, 1'b0);
    cyc(1'b1, mk(32'h311, 9'h6, 3'd2, 5'd4), 1'b0, 1'b0);
    apu_req    = 1'b1;
    apu_result = 32'h312;
    us_ack     = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_rst_count",  64'(count),     64'd0);
    chk("t6_rst_req",    64'(us_req),    64'd0);
    chk("t6_rst_ack",    64'(apu_ack),   64'd1);
    chk("t6_rst_result", 64'(us_result), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    apu_req = 1'b0;
    us_ack  = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_post_rst_count", 64'(count), 64'd0);
    cyc(1'b1, mk(32'h400, 9'h7, 3'd5, 5'd9), 1'b0, 1'b0);
    chk("t6_post_rst_push", 64'(count), 64'd1);
    idle_pop();
    cyc(1'b0, '0, 1'b0, 1'b0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
